// File: rtl/seqsqrt_core_if.sv
// seqsqrt_core_if
//   Request/result bundle for the sequential square-root unit.
//   Parameter NBITS_IN sets the operand width; the result is half as wide.
//   Signals:
//     start  1-cycle request, operand sampled on the same edge
//     xin    NBITS_IN-bit unsigned operand
//     sqrt   NBITS_IN/2-bit unsigned result, held until the next done
//     busy   high while a computation is in progress
//     done   1-cycle pulse when sqrt becomes valid
//   Modports: master drives start/xin, slave (the core) drives sqrt/busy/done.
interface seqsqrt_core_if #(
  parameter int NBITS_IN = 32
);
  localparam int NBITS_OUT = NBITS_IN / 2;

  logic                 start;
  logic [NBITS_IN-1:0]  xin;
  logic [NBITS_OUT-1:0] sqrt;
  logic                 busy;
  logic                 done;

  modport master (
    output start, xin,
    input  sqrt, busy, done
  );

  modport slave (
    input  start, xin,
    output sqrt, busy, done
  );
endinterface

// File: rtl/seqsqrt_core.sv
// seqsqrt_core
//   Sequential integer square root: sqrt = floor(sqrt(xin)), one result bit
//   per clock, MSB first, using the restoring remainder/trial-subtract form
//   (no multiplier).
//   Ports:
//     clock    system clock, all state on the rising edge
//     reset_n  asynchronous active-low reset
//     bus      seqsqrt_core_if.slave (start, xin in; sqrt, busy, done out)
//   Optional macro SQRT_ROUND_EN: adds a ROUND state after CALC that rounds
//   the result to nearest (saturating at all-ones), costing one extra cycle.
//   Without the macro the result is the truncated floor value.
module seqsqrt_core #(
  parameter int NBITS_IN = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  seqsqrt_core_if.slave bus
);
  localparam int NBITS_OUT = NBITS_IN / 2;
  localparam int REM_W     = NBITS_OUT + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NBITS_IN-1:0]  x_q, x_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [NBITS_OUT-1:0] root_q, root_d;
  logic [NBITS_OUT-1:0] mask_q, mask_d;
  logic [NBITS_OUT-1:0] sqrt_q, sqrt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [REM_W+1:0]     rem_shift;
  logic [REM_W+1:0]     trial;
  logic                 step_bit;
  logic [NBITS_OUT-1:0] root_step;
  logic [REM_W-1:0]     rem_step;

  // One restoring-sqrt iteration: bring down the next two operand bits and
  // try subtracting (4*root + 1). The compare runs at full width; the stored
  // remainder never exceeds 2*root, so truncating the difference is exact.
  always_comb begin
    rem_shift = {rem_q, x_q[NBITS_IN-1 -: 2]};
    trial     = {2'b00, root_q, 2'b01};
    step_bit  = (rem_shift >= trial);
    root_step = {root_q[NBITS_OUT-2:0], step_bit};
    if (step_bit) begin
      rem_step = rem_shift[REM_W-1:0] - trial[REM_W-1:0];
    end else begin
      rem_step = rem_shift[REM_W-1:0];
    end
  end

`ifdef SQRT_ROUND_EN
  logic                 round_up;
  logic [NBITS_OUT-1:0] root_rounded;

  // The final remainder is xin - root^2; round up when it exceeds root,
  // but never wrap past the largest representable result.
  always_comb begin
    round_up     = (rem_q > {2'b00, root_q});
    root_rounded = root_q;
    if (round_up && !(&root_q)) begin
      root_rounded = root_q + 1'b1;
    end
  end
`endif

  // Next-state and datapath control. mask walks from MSB to LSB and marks
  // which result bit is being decided; mask[0] flags the last iteration.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rem_d   = rem_q;
    root_d  = root_q;
    mask_d  = mask_q;
    sqrt_d  = sqrt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          x_d     = bus.xin;
          rem_d   = '0;
          root_d  = '0;
          mask_d  = {1'b1, {(NBITS_OUT-1){1'b0}}};
          busy_d  = 1'b1;
        end
      end

      CALC: begin
        x_d    = {x_q[NBITS_IN-3:0], 2'b00};
        rem_d  = rem_step;
        root_d = root_step;
        mask_d = {1'b0, mask_q[NBITS_OUT-1:1]};
        if (mask_q[0]) begin
`ifdef SQRT_ROUND_EN
          state_d = ROUND;
`else
          state_d = IDLE;
          sqrt_d  = root_step;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end

`ifdef SQRT_ROUND_EN
      ROUND: begin
        state_d = IDLE;
        sqrt_d  = root_rounded;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any computation without a done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      mask_q  <= '0;
      sqrt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      mask_q  <= mask_d;
      sqrt_q  <= sqrt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sqrt = sqrt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
